// File: rtl/pipes_pkg.sv
// Shared execute-stage types: M-extension opcodes, fast-path selector and
// opcode classification helpers.
package pipes;

  typedef enum logic [3:0] {
    OP_MUL, OP_MULW, OP_DIV, OP_DIVU, OP_REM, OP_REMU,
    OP_DIVW, OP_DIVUW, OP_REMW, OP_REMUW
  } mdop_t;

  typedef enum logic [1:0] {
    FP_NONE,
    FP_DIVZ,
    FP_OVF
  } fast_t;

  function automatic logic is_div_op(input mdop_t op);
    return !(op == OP_MUL || op == OP_MULW);
  endfunction

  function automatic logic is_signed_op(input mdop_t op);
    return (op == OP_DIV || op == OP_REM || op == OP_DIVW || op == OP_REMW);
  endfunction

  function automatic logic is_w_op(input mdop_t op);
    return (op == OP_MULW || op == OP_DIVW || op == OP_DIVUW ||
            op == OP_REMW || op == OP_REMUW);
  endfunction

  function automatic logic is_rem_op(input mdop_t op);
    return (op == OP_REM || op == OP_REMU || op == OP_REMW || op == OP_REMUW);
  endfunction

endpackage

// File: rtl/muldiv_fixup.sv
// Combinational RISC-V result fixup: sign restoration, divide corner cases
// and W-form sign extension applied to a raw multiplier/divider result.
module muldiv_fixup
  import pipes::*;
(
  input  mdop_t        i_op,
  input  logic         i_neg_q,
  input  logic         i_neg_r,
  input  fast_t        i_fast,
  input  logic [63:0]  i_dividend,
  input  logic [127:0] i_unit_c,
  output logic [63:0]  o_rd
);

  logic [63:0] w_q;
  logic [63:0] w_r;
  logic [63:0] w_sel;

  always_comb begin
    w_q = i_unit_c[63:0];
    w_r = i_unit_c[127:64];
    case (i_fast)
      FP_DIVZ: begin
        w_q = '1;
        w_r = i_dividend;
      end
      FP_OVF: begin
        w_q = i_dividend;
        w_r = '0;
      end
      default: begin
        if (i_neg_q) w_q = 64'd0 - i_unit_c[63:0];
        if (i_neg_r) w_r = 64'd0 - i_unit_c[127:64];
      end
    endcase

    if (is_div_op(i_op)) w_sel = is_rem_op(i_op) ? w_r : w_q;
    else                 w_sel = i_unit_c[63:0];

    o_rd = is_w_op(i_op) ? {{32{w_sel[31]}}, w_sel[31:0]} : w_sel;
  end

endmodule

// File: rtl/muldiv_ctrl.sv
// Multicycle mul/div sequencer: conditions operands, starts the selected unit,
// applies sign/corner fixups and holds the result until execute consumes it.
//   state   | meaning
//   S_IDLE  | ready for a request; divide corner cases resolve here
//   S_ISSUE | one-cycle start pulse to the selected unit
//   S_WAIT  | waiting for the selected unit's done
//   S_RESP  | result held on resp_data until resp_ready
module muldiv_ctrl
  import pipes::*;
(
  input  logic         clk,
  input  logic         resetn,
  input  logic         req_valid,
  output logic         req_ready,
  input  mdop_t        req_op,
  input  logic [63:0]  req_a,
  input  logic [63:0]  req_b,
  input  logic         flush,
  output logic         resp_valid,
  input  logic         resp_ready,
  output logic [63:0]  resp_data,
  output logic         mul_start,
  output logic [63:0]  mul_a,
  output logic [63:0]  mul_b,
  input  logic         mul_done,
  input  logic [127:0] mul_c,
  output logic         div_start,
  output logic [63:0]  div_a,
  output logic [63:0]  div_b,
  input  logic         div_done,
  input  logic [127:0] div_c,
  output logic         unit_kill
);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;

  state_t      r_state, w_state_nxt;
  mdop_t       r_op;
  logic        r_neg_q, r_neg_r, r_resp_valid;
  logic [63:0] r_mul_a, r_mul_b, r_div_a, r_div_b, r_resp_data;

  logic        w_req_w, w_req_signed, w_a_neg, w_b_neg, w_b_zero, w_ovf;
  logic [31:0] w_a_lo, w_b_lo;
  logic [63:0] w_a_mag, w_b_mag, w_fx_rd;
  fast_t       w_req_fast;
  logic        w_accept, w_capture, w_done_sel, w_in_idle;

  // W ops narrow to 32 bits before taking the magnitude
  assign w_req_w      = is_w_op(req_op);
  assign w_req_signed = is_signed_op(req_op);
  assign w_a_neg      = w_req_signed & (w_req_w ? req_a[31] : req_a[63]);
  assign w_b_neg      = w_req_signed & (w_req_w ? req_b[31] : req_b[63]);
  assign w_a_lo       = w_a_neg ? (32'd0 - req_a[31:0]) : req_a[31:0];
  assign w_b_lo       = w_b_neg ? (32'd0 - req_b[31:0]) : req_b[31:0];
  assign w_a_mag      = w_req_w ? {32'd0, w_a_lo} : (w_a_neg ? 64'd0 - req_a : req_a);
  assign w_b_mag      = w_req_w ? {32'd0, w_b_lo} : (w_b_neg ? 64'd0 - req_b : req_b);

  assign w_b_zero = w_req_w ? (req_b[31:0] == 32'd0) : (req_b == 64'd0);
  assign w_ovf    = w_req_signed & (w_req_w ?
                    (req_a[31:0] == 32'h8000_0000 && req_b[31:0] == 32'hFFFF_FFFF) :
                    (req_a == 64'h8000_0000_0000_0000 && req_b == '1));
  assign w_req_fast = !is_div_op(req_op) ? FP_NONE :
                      w_b_zero           ? FP_DIVZ :
                      w_ovf              ? FP_OVF  : FP_NONE;

  // One fixup instance: request-side inputs in IDLE (fast paths), latched ones otherwise
  assign w_in_idle  = (r_state == S_IDLE);
  assign w_done_sel = is_div_op(r_op) ? div_done : mul_done;

  muldiv_fixup u_fixup (
    .i_op       (w_in_idle ? req_op : r_op),
    .i_neg_q    (w_in_idle ? 1'b0 : r_neg_q),
    .i_neg_r    (w_in_idle ? 1'b0 : r_neg_r),
    .i_fast     (w_in_idle ? w_req_fast : FP_NONE),
    .i_dividend (req_a),
    .i_unit_c   (is_div_op(r_op) ? div_c : mul_c),
    .o_rd       (w_fx_rd)
  );

  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_capture   = 1'b0;
    mul_start   = 1'b0;
    div_start   = 1'b0;
    unit_kill   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (req_valid && !flush) begin
          w_accept = 1'b1;
          if (w_req_fast != FP_NONE) begin
            w_capture   = 1'b1;
            w_state_nxt = S_RESP;
          end else begin
            w_state_nxt = S_ISSUE;
          end
        end
      end
      S_ISSUE: begin
        if (flush) begin
          w_state_nxt = S_IDLE;
        end else begin
          mul_start   = !is_div_op(r_op);
          div_start   = is_div_op(r_op);
          w_state_nxt = S_WAIT;
        end
      end
      S_WAIT: begin
        if (flush) begin
          unit_kill   = 1'b1;
          w_state_nxt = S_IDLE;
        end else if (w_done_sel) begin
          w_capture   = 1'b1;
          w_state_nxt = S_RESP;
        end
      end
      S_RESP: begin
        if (flush || resp_ready) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state      <= S_IDLE;
      r_op         <= OP_MUL;
      r_neg_q      <= 1'b0;
      r_neg_r      <= 1'b0;
      r_resp_valid <= 1'b0;
      r_resp_data  <= '0;
      r_mul_a      <= '0;
      r_mul_b      <= '0;
      r_div_a      <= '0;
      r_div_b      <= '0;
    end else begin
      r_state      <= w_state_nxt;
      r_resp_valid <= (w_state_nxt == S_RESP);
      if (w_capture) r_resp_data <= w_fx_rd;
      if (w_accept) begin
        r_op    <= req_op;
        r_neg_q <= w_a_neg ^ w_b_neg;
        r_neg_r <= w_a_neg;
        if (is_div_op(req_op)) begin
          r_div_a <= w_a_mag;
          r_div_b <= w_b_mag;
        end else begin
          r_mul_a <= req_a;
          r_mul_b <= req_b;
        end
      end
    end
  end

  assign req_ready  = (r_state == S_IDLE);
  assign resp_valid = r_resp_valid;
  assign resp_data  = r_resp_data;
  assign mul_a      = r_mul_a;
  assign mul_b      = r_mul_b;
  assign div_a      = r_div_a;
  assign div_b      = r_div_b;

endmodule

// File: tb/tb_muldiv_ctrl.sv
// Directed bench for muldiv_ctrl with behavioural mul/div unit models and a
// queue-based scoreboard checked by an independent response monitor.
module tb_muldiv_ctrl;
  import pipes::*;

  logic         clk, resetn, req_valid, req_ready, flush, resp_valid, resp_ready;
  mdop_t        req_op;
  logic [63:0]  req_a, req_b, resp_data, mul_a, mul_b, div_a, div_b;
  logic         mul_start, mul_done, div_start, div_done, unit_kill;
  logic [127:0] mul_c, div_c;

  int total = 0;
  int bad   = 0;
  int unit_lat = 3;
  int mul_starts = 0;
  int div_starts = 0;
  int mcnt = 0;
  int dcnt = 0;
  logic [63:0] exp_q[$];

  muldiv_ctrl dut (
    .clk(clk), .resetn(resetn), .req_valid(req_valid), .req_ready(req_ready),
    .req_op(req_op), .req_a(req_a), .req_b(req_b), .flush(flush),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_data(resp_data),
    .mul_start(mul_start), .mul_a(mul_a), .mul_b(mul_b), .mul_done(mul_done), .mul_c(mul_c),
    .div_start(div_start), .div_a(div_a), .div_b(div_b), .div_done(div_done), .div_c(div_c),
    .unit_kill(unit_kill)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t, required completion", $time);
    $fatal(1);
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h, required %h", name, act, exp);
    end
  endtask

  // Unit models: done `unit_lat` cycles after the start pulse; kill is not honoured,
  // so a flushed operation still produces a late done.
  initial begin
    logic [127:0] prod;
    mul_done = 1'b0; div_done = 1'b0; mul_c = '0; div_c = '0;
    forever begin
      @(negedge clk); #2;
      mul_done = 1'b0;
      div_done = 1'b0;
      if (mcnt == 1) begin
        prod     = {64'd0, mul_a} * {64'd0, mul_b};
        mul_c    = prod;
        mul_done = 1'b1;
      end
      if (mcnt > 0) mcnt--;
      if (dcnt == 1) begin
        div_c    = (div_b == 64'd0) ? '1 : {div_a % div_b, div_a / div_b};
        div_done = 1'b1;
      end
      if (dcnt > 0) dcnt--;
      if (mul_start) begin mcnt = unit_lat; mul_starts++; end
      if (div_start) begin dcnt = unit_lat; div_starts++; end
    end
  end

  // Scoreboard monitor: every accepted response is compared against the queue head
  initial begin
    logic [63:0] e;
    forever begin
      @(negedge clk); #3;
      if (resp_valid && resp_ready) begin
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL resp_unexpected: got %h, required no response", resp_data);
        end else begin
          e = exp_q.pop_front();
          check("resp_data", resp_data, e);
        end
      end
    end
  end

  task automatic run_op(input mdop_t op, input logic [63:0] a, input logic [63:0] b,
                        input logic [63:0] exp, input bit fast, input int lat);
    int ms0, ds0, n, done_n;
    @(negedge clk);
    unit_lat = lat;
    req_op = op; req_a = a; req_b = b; req_valid = 1'b1;
    exp_q.push_back(exp);
    ms0 = mul_starts; ds0 = div_starts;
    #3 check("req_ready_idle", {63'd0, req_ready}, 64'd1);
    @(negedge clk);
    req_valid = 1'b0;
    #3;
    if (fast) begin
      check("fast_resp_t1", {63'd0, resp_valid}, 64'd1);
    end else begin
      n = 0; done_n = -1;
      while (!resp_valid && n < 40) begin
        if ((mul_done || div_done) && done_n < 0) done_n = n;
        @(negedge clk); #3;
        n++;
      end
      if (!resp_valid) begin
        total++; bad++;
        $display("FAIL resp_timeout: got no resp_valid in %0d cycles, required one", n);
      end else begin
        check("resp_after_done", 64'(n), 64'(done_n + 1));
      end
    end
    n = 0;
    while (!req_ready && n < 10) begin
      @(negedge clk); #3;
      n++;
    end
    check("back_to_idle", {63'd0, req_ready}, 64'd1);
    check("mul_start_count", 64'(mul_starts - ms0), (!fast && !is_div_op(op)) ? 64'd1 : 64'd0);
    check("div_start_count", 64'(div_starts - ds0), (!fast && is_div_op(op)) ? 64'd1 : 64'd0);
  endtask

  initial begin
    int ds0, n;
    resetn = 1'b0; req_valid = 1'b0; req_op = OP_MUL; req_a = '0; req_b = '0;
    flush = 1'b0; resp_ready = 1'b1;
    repeat (2) @(negedge clk);
    #3;
    check("rst_req_ready", {63'd0, req_ready}, 64'd1);
    check("rst_resp_valid", {63'd0, resp_valid}, 64'd0);
    check("rst_resp_data", resp_data, 64'd0);
    check("rst_starts_kill", {61'd0, mul_start, div_start, unit_kill}, 64'd0);
    check("rst_operands", mul_a | mul_b | div_a | div_b, 64'd0);
    @(negedge clk);
    resetn = 1'b1;

    run_op(OP_DIV,   -64'sd7, 64'd2, 64'hFFFF_FFFF_FFFF_FFFD, 1'b0, 5);
    run_op(OP_REM,   -64'sd7, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 5);
    run_op(OP_DIVU,  64'd5, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 3);
    run_op(OP_REMU,  64'd5, 64'd0, 64'd5, 1'b1, 3);
    run_op(OP_DIVW,  64'h8000_0000, 64'hFFFF_FFFF, 64'hFFFF_FFFF_8000_0000, 1'b1, 3);
    run_op(OP_REMW,  64'h8000_0000, 64'hFFFF_FFFF, 64'd0, 1'b1, 3);
    run_op(OP_MULW,  64'h7FFF_FFFF, 64'd2, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 3);
    run_op(OP_MUL,   -64'sd3, 64'd5, 64'hFFFF_FFFF_FFFF_FFF1, 1'b0, 1);
    run_op(OP_DIV,   64'h8000_0000_0000_0000, '1, 64'h8000_0000_0000_0000, 1'b1, 3);
    run_op(OP_REM,   64'h8000_0000_0000_0000, '1, 64'd0, 1'b1, 3);
    run_op(OP_DIVUW, 64'h1_0000_0014, 64'd3, 64'd6, 1'b0, 2);
    run_op(OP_REMUW, 64'h1_0000_0014, 64'd3, 64'd2, 1'b0, 4);
    run_op(OP_DIVW,  64'hFFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFD, 1'b0, 3);
    run_op(OP_REMW,  64'hFFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 3);
    run_op(OP_DIV,   64'd7, -64'sd2, 64'hFFFF_FFFF_FFFF_FFFD, 1'b0, 2);
    run_op(OP_REM,   64'd7, -64'sd2, 64'd1, 1'b0, 2);
    run_op(OP_REM,   -64'sd7, 64'd0, 64'hFFFF_FFFF_FFFF_FFF9, 1'b1, 3);
    run_op(OP_DIVW,  64'd5, 64'h1_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 3);
    run_op(OP_REMW,  64'd5, 64'h1_0000_0000, 64'd5, 1'b1, 3);

    // Back-pressure: response held while resp_ready is low
    @(negedge clk);
    resp_ready = 1'b0;
    req_op = OP_REMU; req_a = 64'd9; req_b = 64'd0; req_valid = 1'b1;
    exp_q.push_back(64'd9);
    @(negedge clk);
    req_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      #3;
      check("hold_valid", {63'd0, resp_valid}, 64'd1);
      check("hold_data", resp_data, 64'd9);
      check("hold_req_ready", {63'd0, req_ready}, 64'd0);
      @(negedge clk);
    end
    resp_ready = 1'b1;
    @(negedge clk); #3;
    check("release_idle", {63'd0, req_ready}, 64'd1);
    check("release_valid", {63'd0, resp_valid}, 64'd0);

    // Flush two cycles into WAIT; the late div_done must not produce a response
    @(negedge clk);
    unit_lat = 8;
    req_op = OP_DIV; req_a = 64'd100; req_b = 64'd7; req_valid = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
    #3 check("flush_issue_start", {63'd0, div_start}, 64'd1);
    @(negedge clk);
    @(negedge clk);
    flush = 1'b1;
    #3 check("flush_kill", {63'd0, unit_kill}, 64'd1);
    @(negedge clk);
    flush = 1'b0;
    #3;
    check("flush_req_ready", {63'd0, req_ready}, 64'd1);
    check("flush_no_valid", {63'd0, resp_valid}, 64'd0);
    check("flush_kill_once", {63'd0, unit_kill}, 64'd0);
    n = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk); #3;
      if (resp_valid) n++;
    end
    check("late_done_ignored", 64'(n), 64'd0);

    // Flush coincident with a request: request is not accepted
    ds0 = div_starts;
    @(negedge clk);
    req_op = OP_DIV; req_a = 64'd50; req_b = 64'd5; req_valid = 1'b1; flush = 1'b1;
    @(negedge clk);
    req_valid = 1'b0; flush = 1'b0;
    #3;
    check("flush_req_still_idle", {63'd0, req_ready}, 64'd1);
    repeat (4) @(negedge clk);
    #3;
    check("flush_req_no_start", 64'(div_starts - ds0), 64'd0);
    check("flush_req_no_valid", {63'd0, resp_valid}, 64'd0);

    repeat (2) @(negedge clk);
    check("queue_drained", 64'(exp_q.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
